// File: rtl/llc_ctrl_regs_gen_pkg.sv
// rtl/llc_ctrl_regs_gen_pkg.sv - shared LLC control-register types and flush FSM state encoding
package llc_ctrl_regs_gen_pkg;

  localparam int LLC_DEF_N_SETS = 256;
  localparam int LLC_DEF_N_WAYS = 16;
  localparam int LLC_DEF_N_MSHR = 16;

  typedef logic [$clog2(LLC_DEF_N_SETS)-1:0]   llc_set_t;
  typedef logic [$clog2(LLC_DEF_N_WAYS)-1:0]   llc_way_t;
  typedef logic [$clog2(LLC_DEF_N_MSHR+1)-1:0] mshr_cnt_t;

  typedef enum logic [1:0] {
    FLUSH_IDLE = 2'd0,
    FLUSH_WALK = 2'd1,
    FLUSH_DONE = 2'd2
  } llc_flush_state_t;

endpackage

// File: rtl/llc_ctrl_regs_gen_flush_walker.sv
// rtl/llc_ctrl_regs_gen_flush_walker.sv - flush walker FSM visiting every set/way over valid/ready
// Optional abort input when LLC_FLUSH_ABORT_EN is defined.
module llc_flush_walker
  import llc_ctrl_regs_gen_pkg::*;
#(
  parameter int N_SETS = 256,
  parameter int N_WAYS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_start,
`ifdef LLC_FLUSH_ABORT_EN
  input  logic                      flush_abort,
`endif
  input  logic                      flush_req_ready,
  output logic                      flush_busy,
  output logic                      flush_req_valid,
  output logic [$clog2(N_SETS)-1:0] flush_req_set,
  output logic [$clog2(N_WAYS)-1:0] flush_req_way,
  output logic                      flush_done
);

  localparam int SW = $clog2(N_SETS);
  localparam int WW = $clog2(N_WAYS);
  localparam logic [SW-1:0] SET_LAST = SW'(N_SETS - 1);
  localparam logic [WW-1:0] WAY_LAST = WW'(N_WAYS - 1);

  llc_flush_state_t state_q, state_d;
  logic [SW-1:0]    set_q, set_d;
  logic [WW-1:0]    way_q, way_d;
  logic             abort;

`ifdef LLC_FLUSH_ABORT_EN
  assign abort = flush_abort;
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FLUSH_IDLE;
      set_q   <= '0;
      way_q   <= '0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      way_q   <= way_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    set_d           = set_q;
    way_d           = way_q;
    flush_busy      = 1'b0;
    flush_req_valid = 1'b0;
    flush_done      = 1'b0;
    case (state_q)
      FLUSH_IDLE: begin
        if (flush_start) begin
          state_d = FLUSH_WALK;
          set_d   = '0;
          way_d   = '0;
        end
      end
      FLUSH_WALK: begin
        flush_busy      = 1'b1;
        flush_req_valid = 1'b1;
        // An abort wins over advancing; a coincident handshake is still taken as accepted.
        if (abort) begin
          state_d = FLUSH_DONE;
          set_d   = '0;
          way_d   = '0;
        end else if (flush_req_ready) begin
          if (way_q == WAY_LAST) begin
            way_d = '0;
            if (set_q == SET_LAST) begin
              state_d = FLUSH_DONE;
              set_d   = '0;
            end else begin
              set_d = set_q + SW'(1);
            end
          end else begin
            way_d = way_q + WW'(1);
          end
        end
      end
      FLUSH_DONE: begin
        flush_busy = 1'b1;
        flush_done = 1'b1;
        state_d    = FLUSH_IDLE;
      end
      default: state_d = FLUSH_IDLE;
    endcase
  end

  assign flush_req_set = set_q;
  assign flush_req_way = way_q;

endmodule

// File: rtl/llc_ctrl_regs_gen.sv
// rtl/llc_ctrl_regs_gen.sv - LLC control registers: MSHR credit counter, stall flags, flush walker
// Optional flush_abort port when LLC_FLUSH_ABORT_EN is defined.
module llc_ctrl_regs_gen
  import llc_ctrl_regs_gen_pkg::*;
#(
  parameter int N_MSHR  = 16,
  parameter int N_SETS  = 256,
  parameter int N_WAYS  = 16,
  parameter int N_FLAGS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alloc_mshr,
  input  logic                         free_mshr,
  output logic [$clog2(N_MSHR+1)-1:0]  mshr_cnt,
  output logic                         mshr_avail,
  output logic                         mshr_err,
  input  logic [N_FLAGS-1:0]           flag_set,
  input  logic [N_FLAGS-1:0]           flag_clr,
  output logic [N_FLAGS-1:0]           flags,
  input  logic                         flush_start,
`ifdef LLC_FLUSH_ABORT_EN
  input  logic                         flush_abort,
`endif
  output logic                         flush_busy,
  output logic                         flush_req_valid,
  input  logic                         flush_req_ready,
  output logic [$clog2(N_SETS)-1:0]    flush_req_set,
  output logic [$clog2(N_WAYS)-1:0]    flush_req_way,
  output logic                         flush_done
);

  localparam int CW = $clog2(N_MSHR + 1);
  localparam logic [CW-1:0] MSHR_MAX = CW'(N_MSHR);

  logic [CW-1:0]      cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [N_FLAGS-1:0] flags_q, flags_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= MSHR_MAX;
      err_q   <= 1'b0;
      flags_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      flags_q <= flags_d;
    end
  end

  // Simultaneous alloc+free cancels out, so it can never over/underflow.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    case ({alloc_mshr, free_mshr})
      2'b10: begin
        if (cnt_q == '0) err_d = 1'b1;
        else             cnt_d = cnt_q - CW'(1);
      end
      2'b01: begin
        if (cnt_q == MSHR_MAX) err_d = 1'b1;
        else                   cnt_d = cnt_q + CW'(1);
      end
      default: ;
    endcase
    flags_d = (flags_q | flag_set) & ~flag_clr;
  end

  assign mshr_cnt   = cnt_q;
  assign mshr_avail = (cnt_q != '0);
  assign mshr_err   = err_q;
  assign flags      = flags_q;

  llc_flush_walker #(
    .N_SETS (N_SETS),
    .N_WAYS (N_WAYS)
  ) u_flush_walker (
    .clk             (clk),
    .rst             (rst),
    .flush_start     (flush_start),
`ifdef LLC_FLUSH_ABORT_EN
    .flush_abort     (flush_abort),
`endif
    .flush_req_ready (flush_req_ready),
    .flush_busy      (flush_busy),
    .flush_req_valid (flush_req_valid),
    .flush_req_set   (flush_req_set),
    .flush_req_way   (flush_req_way),
    .flush_done      (flush_done)
  );

endmodule

// File: tb/tb_llc_ctrl_regs_gen.sv
// tb/tb_llc_ctrl_regs_gen.sv - directed self-checking bench for llc_ctrl_regs_gen (N_MSHR=4, 4x2 cache)
module tb_llc_ctrl_regs_gen;

  localparam int TB_MSHR  = 4;
  localparam int TB_SETS  = 4;
  localparam int TB_WAYS  = 2;
  localparam int TB_FLAGS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       alloc_mshr = 1'b0;
  logic       free_mshr = 1'b0;
  logic [2:0] mshr_cnt;
  logic       mshr_avail;
  logic       mshr_err;
  logic [3:0] flag_set = '0;
  logic [3:0] flag_clr = '0;
  logic [3:0] flags;
  logic       flush_start = 1'b0;
`ifdef LLC_FLUSH_ABORT_EN
  logic       flush_abort = 1'b0;
`endif
  logic       flush_busy;
  logic       flush_req_valid;
  logic       flush_req_ready = 1'b0;
  logic [1:0] flush_req_set;
  logic [0:0] flush_req_way;
  logic       flush_done;

  int vec = 0;
  int mis = 0;

  always #5 clk = ~clk;

  llc_ctrl_regs_gen #(
    .N_MSHR  (TB_MSHR),
    .N_SETS  (TB_SETS),
    .N_WAYS  (TB_WAYS),
    .N_FLAGS (TB_FLAGS)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .alloc_mshr      (alloc_mshr),
    .free_mshr       (free_mshr),
    .mshr_cnt        (mshr_cnt),
    .mshr_avail      (mshr_avail),
    .mshr_err        (mshr_err),
    .flag_set        (flag_set),
    .flag_clr        (flag_clr),
    .flags           (flags),
    .flush_start     (flush_start),
`ifdef LLC_FLUSH_ABORT_EN
    .flush_abort     (flush_abort),
`endif
    .flush_busy      (flush_busy),
    .flush_req_valid (flush_req_valid),
    .flush_req_ready (flush_req_ready),
    .flush_req_set   (flush_req_set),
    .flush_req_way   (flush_req_way),
    .flush_done      (flush_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    vec++;
    if (mshr_cnt !== 3'd4 || mshr_avail !== 1'b1 || mshr_err !== 1'b0) begin
      $display("FAIL reset_mshr cnt=%0d avail=%0b err=%0b required cnt=4 avail=1 err=0", mshr_cnt, mshr_avail, mshr_err);
      mis++;
    end
    vec++;
    if (flags !== 4'b0000 || flush_busy !== 1'b0 || flush_req_valid !== 1'b0 || flush_done !== 1'b0) begin
      $display("FAIL reset_flush flags=%b busy=%0b valid=%0b done=%0b required all 0", flags, flush_busy, flush_req_valid, flush_done);
      mis++;
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_mshr_alloc();
    for (int i = 0; i < 4; i++) begin
      alloc_mshr = 1'b1;
      step();
      vec++;
      if (mshr_cnt !== 3'(3 - i)) begin
        $display("FAIL alloc_cnt[%0d] got %0d required %0d", i, mshr_cnt, 3 - i);
        mis++;
      end
    end
    alloc_mshr = 1'b0;
    vec++;
    if (mshr_avail !== 1'b0 || mshr_err !== 1'b0) begin
      $display("FAIL alloc_empty avail=%0b err=%0b required avail=0 err=0", mshr_avail, mshr_err);
      mis++;
    end
    alloc_mshr = 1'b1;
    step();
    alloc_mshr = 1'b0;
    vec++;
    if (mshr_cnt !== 3'd0 || mshr_err !== 1'b1) begin
      $display("FAIL alloc_underflow cnt=%0d err=%0b required cnt=0 err=1", mshr_cnt, mshr_err);
      mis++;
    end
    free_mshr = 1'b1;
    repeat (4) step();
    free_mshr = 1'b0;
    vec++;
    if (mshr_cnt !== 3'd4 || mshr_err !== 1'b1 || mshr_avail !== 1'b1) begin
      $display("FAIL err_sticky cnt=%0d err=%0b avail=%0b required cnt=4 err=1 avail=1", mshr_cnt, mshr_err, mshr_avail);
      mis++;
    end
    apply_reset();
  endtask

  task automatic test_mshr_simul();
    alloc_mshr = 1'b1;
    repeat (2) step();
    free_mshr = 1'b1;
    step();
    vec++;
    if (mshr_cnt !== 3'd2 || mshr_err !== 1'b0) begin
      $display("FAIL alloc_free_same cnt=%0d err=%0b required cnt=2 err=0", mshr_cnt, mshr_err);
      mis++;
    end
    alloc_mshr = 1'b0;
    repeat (2) step();
    vec++;
    if (mshr_cnt !== 3'd4 || mshr_err !== 1'b0) begin
      $display("FAIL free_to_full cnt=%0d err=%0b required cnt=4 err=0", mshr_cnt, mshr_err);
      mis++;
    end
    step();
    free_mshr = 1'b0;
    vec++;
    if (mshr_cnt !== 3'd4 || mshr_err !== 1'b1) begin
      $display("FAIL free_overflow cnt=%0d err=%0b required cnt=4 err=1", mshr_cnt, mshr_err);
      mis++;
    end
    apply_reset();
  endtask

  task automatic test_flags();
    flag_set = 4'b0101;
    vec++;
    if (flags !== 4'b0000) begin
      $display("FAIL flag_not_early got %b required 0000", flags);
      mis++;
    end
    step();
    vec++;
    if (flags !== 4'b0101) begin
      $display("FAIL flag_set got %b required 0101", flags);
      mis++;
    end
    flag_set = 4'b0001;
    flag_clr = 4'b0001;
    step();
    vec++;
    if (flags !== 4'b0100) begin
      $display("FAIL flag_clr_priority got %b required 0100", flags);
      mis++;
    end
    flag_set = 4'b0000;
    flag_clr = 4'b1111;
    step();
    flag_clr = 4'b0000;
    vec++;
    if (flags !== 4'b0000) begin
      $display("FAIL flag_clr_all got %b required 0000", flags);
      mis++;
    end
  endtask

  task automatic test_flush_full();
    int hs = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int cyc = 1;
    flush_req_ready = 1'b1;
    flush_start = 1'b1;
    step();
    flush_start = 1'b0;
    cyc = 2;
    for (int k = 0; k < 30; k++) begin
      if (flush_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (flush_req_valid && flush_req_ready) begin
        vec++;
        if (int'(flush_req_set) !== hs / TB_WAYS || int'(flush_req_way) !== hs % TB_WAYS) begin
          $display("FAIL full_req[%0d] got (%0d,%0d) required (%0d,%0d)", hs, flush_req_set, flush_req_way, hs / TB_WAYS, hs % TB_WAYS);
          mis++;
        end
        hs++;
      end
      step();
      cyc++;
    end
    flush_req_ready = 1'b0;
    vec++;
    if (hs !== 8 || done_cnt !== 1 || done_cyc !== 10) begin
      $display("FAIL full_walk hs=%0d done=%0d done_cycle=%0d required hs=8 done=1 done_cycle=10", hs, done_cnt, done_cyc);
      mis++;
    end
    vec++;
    if (flush_busy !== 1'b0 || flush_req_valid !== 1'b0) begin
      $display("FAIL full_idle busy=%0b valid=%0b required 0 0", flush_busy, flush_req_valid);
      mis++;
    end
  endtask

  task automatic test_flush_toggle();
    int hs = 0;
    int done_cnt = 0;
    logic       prev_stall = 1'b0;
    logic [1:0] prev_set = '0;
    logic [0:0] prev_way = '0;
    flush_start = 1'b1;
    step();
    flush_start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (flush_done) done_cnt++;
      if (prev_stall && flush_req_valid) begin
        vec++;
        if (flush_req_set !== prev_set || flush_req_way !== prev_way) begin
          $display("FAIL toggle_stable got (%0d,%0d) required (%0d,%0d)", flush_req_set, flush_req_way, prev_set, prev_way);
          mis++;
        end
      end
      flush_req_ready = k[0];
      flush_start = (k == 5);
      prev_stall = flush_req_valid && !flush_req_ready;
      prev_set = flush_req_set;
      prev_way = flush_req_way;
      if (flush_req_valid && flush_req_ready) begin
        vec++;
        if (int'(flush_req_set) !== hs / TB_WAYS || int'(flush_req_way) !== hs % TB_WAYS) begin
          $display("FAIL toggle_req[%0d] got (%0d,%0d) required (%0d,%0d)", hs, flush_req_set, flush_req_way, hs / TB_WAYS, hs % TB_WAYS);
          mis++;
        end
        hs++;
      end
      step();
    end
    flush_req_ready = 1'b0;
    flush_start = 1'b0;
    vec++;
    if (hs !== 8 || done_cnt !== 1 || flush_busy !== 1'b0) begin
      $display("FAIL toggle_walk hs=%0d done=%0d busy=%0b required hs=8 done=1 busy=0", hs, done_cnt, flush_busy);
      mis++;
    end
  endtask

  task automatic test_flush_reset();
    int k = 0;
    int done_cnt = 0;
    flush_req_ready = 1'b1;
    flush_start = 1'b1;
    step();
    flush_start = 1'b0;
    while (!(flush_req_valid && flush_req_set == 2'd2 && flush_req_way == 1'b1) && k < 20) begin
      step();
      k++;
    end
    vec++;
    if (k >= 20) begin
      $display("FAIL reset_reach_21 timeout set=%0d way=%0d required (2,1)", flush_req_set, flush_req_way);
      mis++;
    end
    rst = 1'b0;
    #1;
    vec++;
    if (flush_req_valid !== 1'b0 || flush_busy !== 1'b0) begin
      $display("FAIL reset_async valid=%0b busy=%0b required 0 0", flush_req_valid, flush_busy);
      mis++;
    end
    step();
    rst = 1'b1;
    for (int j = 0; j < 4; j++) begin
      step();
      if (flush_done) done_cnt++;
    end
    flush_req_ready = 1'b0;
    vec++;
    if (flush_req_valid !== 1'b0 || flush_busy !== 1'b0 || done_cnt !== 0 || flush_req_set !== 2'd0) begin
      $display("FAIL reset_abandon valid=%0b busy=%0b done=%0d set=%0d required 0 0 0 0", flush_req_valid, flush_busy, done_cnt, flush_req_set);
      mis++;
    end
  endtask

`ifdef LLC_FLUSH_ABORT_EN
  task automatic test_flush_abort();
    flush_req_ready = 1'b1;
    flush_start = 1'b1;
    step();
    flush_start = 1'b0;
    step();
    step();
    vec++;
    if (flush_req_valid !== 1'b1 || flush_req_set !== 2'd1 || flush_req_way !== 1'b0) begin
      $display("FAIL abort_reach_10 valid=%0b set=%0d way=%0d required 1 (1,0)", flush_req_valid, flush_req_set, flush_req_way);
      mis++;
    end
    flush_abort = 1'b1;
    step();
    flush_abort = 1'b0;
    flush_req_ready = 1'b0;
    vec++;
    if (flush_done !== 1'b1 || flush_req_valid !== 1'b0 || flush_req_set !== 2'd0 || flush_req_way !== 1'b0) begin
      $display("FAIL abort_done done=%0b valid=%0b set=%0d way=%0d required 1 0 0 0", flush_done, flush_req_valid, flush_req_set, flush_req_way);
      mis++;
    end
    step();
    vec++;
    if (flush_done !== 1'b0 || flush_busy !== 1'b0) begin
      $display("FAIL abort_idle done=%0b busy=%0b required 0 0", flush_done, flush_busy);
      mis++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_mshr_alloc();
    test_mshr_simul();
    test_flags();
    test_flush_full();
    test_flush_toggle();
    test_flush_reset();
`ifdef LLC_FLUSH_ABORT_EN
    test_flush_abort();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule

// File: doc/llc_ctrl_regs_gen.md
Name: llc_ctrl_regs_gen

Overview:
Parametrised LLC control-register block for the Spandex LLC.
- Holds the MSHR credit counter, which is saturation-safe and supports a simultaneous allocate and free.
- Holds a vector of generic set/clear stall flags.
- Contains a flush walker FSM that visits every set and way. Each visit is offered to the LLC datapath through a valid/ready handshake.
- Sits beside the LLC FSM. The FSM drives single-cycle triggers; this block returns registered state.

Parameters:
N_MSHR, 16, number of MSHR entries (counter reset value).
N_SETS, 256, LLC sets; power of two, at least 2.
N_WAYS, 16, LLC ways; power of two, at least 2.
N_FLAGS, 4, number of generic set/clear status flags.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
alloc_mshr  in  1  consume one MSHR credit
free_mshr  in  1  return one MSHR credit
mshr_cnt  out  $clog2(N_MSHR+1)  free MSHR credits
mshr_avail  out  1  mshr_cnt != 0
mshr_err  out  1  sticky over/underflow error
flag_set  in  N_FLAGS  per-bit set trigger
flag_clr  in  N_FLAGS  per-bit clear trigger
flags  out  N_FLAGS  registered flag state
flush_start  in  1  begin a full-cache flush walk
flush_busy  out  1  walk in progress (WALK or DONE state)
flush_req_valid  out  1  flush request for set/way below
flush_req_ready  in  1  datapath accepts the current request
flush_req_set  out  $clog2(N_SETS)  set index of request
flush_req_way  out  $clog2(N_WAYS)  way index of request
flush_done  out  1  one-cycle pulse when the walk completes

Behaviour:
Reset values:
- mshr_cnt = N_MSHR; mshr_err = 0; flags = 0.
- FSM = IDLE; flush_set = 0; flush_way = 0; all flush outputs 0.
- Reset mid-walk abandons the walk immediately. No flush_done pulse is produced.

MSHR counter (next-cycle update):
- alloc only: decrement.
- free only: increment.
- alloc and free together: counter unchanged, no error.
- alloc only with mshr_cnt==0: counter holds, mshr_err <= 1.
- free only with mshr_cnt==N_MSHR: counter holds, mshr_err <= 1.
- mshr_err is cleared only by reset.

Flags:
- Per bit, clear has priority over set.
- The update is visible on the cycle after the trigger.

Flush FSM states: IDLE, WALK, DONE.
- IDLE: flush_start=1 leads to WALK next cycle with set=0, way=0.
- WALK:
  - flush_req_valid=1 for the whole state.
  - set/way are driven directly from registers and stay stable until accepted.
  - Handshake (valid & ready): way+1. When way==N_WAYS-1, way wraps to 0 and set+1.
  - Handshake at set==N_SETS-1, way==N_WAYS-1: go to DONE; set/way reset to 0.
- DONE: flush_done=1 for one cycle, then IDLE.
- flush_start is ignored outside IDLE.
- Total requests per walk = N_SETS*N_WAYS.
- Minimum latency from flush_start to flush_done = N_SETS*N_WAYS + 2 cycles, with ready held high.

Optional Feature:
Macro: LLC_FLUSH_ABORT_EN.
- Defined: adds input flush_abort (1 bit).
  - flush_abort in WALK leads to DONE next cycle and clears set/way.
  - A handshake in the same cycle as the abort still counts as accepted. The counters do not advance.
  - flush_done pulses normally.
- Undefined: no port. A walk always covers every set and way.

Decomposition:
- Shared package (spandex_consts/spandex_types): llc_set_t, llc_way_t, mshr_cnt_t, and the flush FSM state enum llc_flush_state_t.
- One sub-module, llc_flush_walker: the FSM plus the set/way counters and handshake.
- The MSHR counter and flags stay in the top module.

Test Plan:
1. N_MSHR=4: 4 allocs -> mshr_cnt 3,2,1,0, mshr_avail=0. A 5th alloc -> cnt stays 0, mshr_err=1, and err persists after 4 frees.
2. cnt=2, alloc and free in the same cycle -> cnt stays 2, err stays 0. Free at cnt=4 -> cnt 4, err=1.
3. flag_set=4'b0101, then flag_set=4'b0001 with flag_clr=4'b0001 -> flags=4'b0101 then 4'b0100.
4. N_SETS=4, N_WAYS=2, ready held at 1 -> requests (0,0),(0,1),(1,0)…(3,1): 8 handshakes, then a single flush_done pulse 10 cycles after start.
5. Ready toggled 1/0 each cycle -> set/way stable while ready=0, no request skipped or duplicated, 8 handshakes total. flush_start mid-walk is ignored.
6. Reset asserted mid-walk at (2,1) -> after release: IDLE, valid=0, busy=0, no flush_done. With LLC_FLUSH_ABORT_EN: abort at (1,0) -> flush_done next cycle, then IDLE.
